// File: rtl/card_scan_if.sv
// -----------------------------------------------------------------------------
// card_scan_if
// Bundles the two buses that the card scan controller drives: the card
// register-file read port and the hit-checker load/enable/result port.
//
// Parameters:
//   IDX_W            width of the card index / register-file address
// Signals:
//   rf_addr          register-file read address            (master -> slave)
//   rf_rd_en         register-file read strobe             (master -> slave)
//   rf_data          {y[9:0], x[9:0]} of the addressed card (slave -> master)
//   chk_sync         checker load strobe                   (master -> slave)
//   chk_yx_position  position presented with chk_sync      (master -> slave)
//   chk_sync_done    checker load acknowledge              (slave -> master)
//   chk_enable       checker enable                        (master -> slave)
//   chk_event_kind   checker event qualifier (press)       (master -> slave)
//   chk_mouse_xpos   click x latched at click              (master -> slave)
//   chk_mouse_ypos   click y latched at click              (master -> slave)
//   chk_event        registered checker hit result         (slave -> master)
// Modports: master (the scan controller), slave (register file + checker).
// -----------------------------------------------------------------------------
interface card_scan_if #(
    parameter int IDX_W = 4
);
    logic [IDX_W-1:0] rf_addr;
    logic             rf_rd_en;
    logic [19:0]      rf_data;
    logic             chk_sync;
    logic [19:0]      chk_yx_position;
    logic             chk_sync_done;
    logic             chk_enable;
    logic             chk_event_kind;
    logic [11:0]      chk_mouse_xpos;
    logic [11:0]      chk_mouse_ypos;
    logic             chk_event;

    modport master (
        output rf_addr,
        output rf_rd_en,
        input  rf_data,
        output chk_sync,
        output chk_yx_position,
        input  chk_sync_done,
        output chk_enable,
        output chk_event_kind,
        output chk_mouse_xpos,
        output chk_mouse_ypos,
        input  chk_event
    );

    modport slave (
        input  rf_addr,
        input  rf_rd_en,
        output rf_data,
        input  chk_sync,
        input  chk_yx_position,
        output chk_sync_done,
        input  chk_enable,
        input  chk_event_kind,
        input  chk_mouse_xpos,
        input  chk_mouse_ypos,
        output chk_event
    );
endinterface

// File: rtl/card_scan_controller.sv
// -----------------------------------------------------------------------------
// card_scan_controller
// After each mouse click, walks every card on the board through a single
// shared hit-test datapath: reads the card position from the register file,
// loads it into the checker, fires one check and reports the first (lowest
// index) card hit, or a miss once the last card has been examined.
//
// Optional build macro: CARD_SCAN_SYNC_TIMEOUT_EN
//   When defined, a wait for chk_sync_done longer than SYNC_TIMEOUT cycles
//   aborts the scan with a one-cycle sync_err pulse. When undefined, the wait
//   is unbounded and sync_err is constant 0.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   click       single-cycle left-click pulse
//   mouse_xpos  live mouse x
//   mouse_ypos  live mouse y
//   card_mask   1 = card in play, 0 = skip (sampled once per card)
//   bus         register-file / checker interface (master side)
//   busy        scan in progress
//   hit_valid   one-cycle pulse: a card was hit
//   hit_idx     index of the hit card, held until the next hit
//   miss        one-cycle pulse: scan ended with no hit
//   sync_err    one-cycle pulse: checker load acknowledge timed out
//
// Every output comes straight from a flop. Strobes are registered from the
// next state, so each strobe is high for exactly the cycle the FSM spends in
// the matching state (rf_rd_en in READ, chk_sync in LOAD, chk_enable in CHECK).
// -----------------------------------------------------------------------------
module card_scan_controller #(
    parameter int N_CARDS      = 16,
    parameter int IDX_W        = 4,
    parameter int SYNC_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               click,
    input  logic [11:0]        mouse_xpos,
    input  logic [11:0]        mouse_ypos,
    input  logic [N_CARDS-1:0] card_mask,
    card_scan_if.master        bus,
    output logic               busy,
    output logic               hit_valid,
    output logic [IDX_W-1:0]   hit_idx,
    output logic               miss,
    output logic               sync_err
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_READ      = 3'd2,
        ST_LOAD      = 3'd3,
        ST_WAIT_SYNC = 3'd4,
        ST_CHECK     = 3'd5,
        ST_EVAL      = 3'd6
    } state_t;

    state_t           state_r,      state_s;
    logic [IDX_W-1:0] idx_r,        idx_s;
    logic [IDX_W-1:0] rf_addr_r,    rf_addr_s;
    logic             rf_rd_en_r,   rf_rd_en_s;
    logic             chk_sync_r,   chk_sync_s;
    logic [19:0]      yx_pos_r,     yx_pos_s;
    logic             chk_enable_r, chk_enable_s;
    logic [11:0]      mouse_x_r,    mouse_x_s;
    logic [11:0]      mouse_y_r,    mouse_y_s;
    logic             busy_r,       busy_s;
    logic             hit_valid_r,  hit_valid_s;
    logic [IDX_W-1:0] hit_idx_r,    hit_idx_s;
    logic             miss_r,       miss_s;
    logic             last_card_s;

`ifdef CARD_SCAN_SYNC_TIMEOUT_EN
    // Counter only needs to reach SYNC_TIMEOUT-1 before the abort fires.
    localparam int TMO_W = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;

    logic [TMO_W-1:0] tmo_cnt_r,  tmo_cnt_s;
    logic             sync_err_r, sync_err_s;
`else
    // The timeout length only matters when the timeout logic is built.
    localparam int unused_sync_timeout = SYNC_TIMEOUT;
`endif

    // Index of the final card; idx never advances past it.
    assign last_card_s = (idx_r == IDX_W'(N_CARDS - 1));

    // Next-state and next-output decode for the scan sequencer.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        rf_addr_s    = rf_addr_r;
        rf_rd_en_s   = 1'b0;
        chk_sync_s   = 1'b0;
        yx_pos_s     = yx_pos_r;
        chk_enable_s = 1'b0;
        mouse_x_s    = mouse_x_r;
        mouse_y_s    = mouse_y_r;
        busy_s       = busy_r;
        hit_valid_s  = 1'b0;
        hit_idx_s    = hit_idx_r;
        miss_s       = 1'b0;
`ifdef CARD_SCAN_SYNC_TIMEOUT_EN
        tmo_cnt_s    = tmo_cnt_r;
        sync_err_s   = 1'b0;
`endif

        case (state_r)
            ST_IDLE: begin
                // Clicks are only looked at here, so a click during a scan is dropped.
                if (click) begin
                    mouse_x_s = mouse_xpos;
                    mouse_y_s = mouse_ypos;
                    idx_s     = {IDX_W{1'b0}};
                    busy_s    = 1'b1;
                    state_s   = ST_SELECT;
                end else begin
                    state_s   = ST_IDLE;
                end
            end

            ST_SELECT: begin
                if (card_mask[idx_r]) begin
                    rf_addr_s  = idx_r;
                    rf_rd_en_s = 1'b1;
                    state_s    = ST_READ;
                end else if (last_card_s) begin
                    miss_s     = 1'b1;
                    busy_s     = 1'b0;
                    state_s    = ST_IDLE;
                end else begin
                    idx_s      = idx_r + IDX_W'(1);
                    state_s    = ST_SELECT;
                end
            end

            ST_READ: begin
                // Read data is valid while the strobe is high; chk_sync goes
                // out together with the captured position.
                yx_pos_s   = bus.rf_data;
                chk_sync_s = 1'b1;
                state_s    = ST_LOAD;
            end

            ST_LOAD: begin
`ifdef CARD_SCAN_SYNC_TIMEOUT_EN
                tmo_cnt_s = {TMO_W{1'b0}};
`endif
                state_s   = ST_WAIT_SYNC;
            end

            ST_WAIT_SYNC: begin
                if (bus.chk_sync_done) begin
                    chk_enable_s = 1'b1;
                    state_s      = ST_CHECK;
`ifdef CARD_SCAN_SYNC_TIMEOUT_EN
                end else if (tmo_cnt_r == TMO_W'(SYNC_TIMEOUT - 1)) begin
                    // Acknowledge arriving on the deadline cycle still wins.
                    sync_err_s   = 1'b1;
                    busy_s       = 1'b0;
                    state_s      = ST_IDLE;
                end else begin
                    tmo_cnt_s    = tmo_cnt_r + TMO_W'(1);
                    state_s      = ST_WAIT_SYNC;
`else
                end else begin
                    state_s      = ST_WAIT_SYNC;
`endif
                end
            end

            ST_CHECK: begin
                state_s = ST_EVAL;
            end

            ST_EVAL: begin
                if (bus.chk_event) begin
                    hit_idx_s   = idx_r;
                    hit_valid_s = 1'b1;
                    busy_s      = 1'b0;
                    state_s     = ST_IDLE;
                end else if (last_card_s) begin
                    miss_s      = 1'b1;
                    busy_s      = 1'b0;
                    state_s     = ST_IDLE;
                end else begin
                    idx_s       = idx_r + IDX_W'(1);
                    state_s     = ST_SELECT;
                end
            end

            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IDX_W{1'b0}};
            rf_addr_r    <= {IDX_W{1'b0}};
            rf_rd_en_r   <= 1'b0;
            chk_sync_r   <= 1'b0;
            yx_pos_r     <= 20'd0;
            chk_enable_r <= 1'b0;
            mouse_x_r    <= 12'd0;
            mouse_y_r    <= 12'd0;
            busy_r       <= 1'b0;
            hit_valid_r  <= 1'b0;
            hit_idx_r    <= {IDX_W{1'b0}};
            miss_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            rf_addr_r    <= rf_addr_s;
            rf_rd_en_r   <= rf_rd_en_s;
            chk_sync_r   <= chk_sync_s;
            yx_pos_r     <= yx_pos_s;
            chk_enable_r <= chk_enable_s;
            mouse_x_r    <= mouse_x_s;
            mouse_y_r    <= mouse_y_s;
            busy_r       <= busy_s;
            hit_valid_r  <= hit_valid_s;
            hit_idx_r    <= hit_idx_s;
            miss_r       <= miss_s;
        end
    end

`ifdef CARD_SCAN_SYNC_TIMEOUT_EN
    // Sync-acknowledge timeout counter and abort pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_r  <= {TMO_W{1'b0}};
            sync_err_r <= 1'b0;
        end else begin
            tmo_cnt_r  <= tmo_cnt_s;
            sync_err_r <= sync_err_s;
        end
    end

    assign sync_err = sync_err_r;
`else
    assign sync_err = 1'b0;
`endif

    assign bus.rf_addr         = rf_addr_r;
    assign bus.rf_rd_en        = rf_rd_en_r;
    assign bus.chk_sync        = chk_sync_r;
    assign bus.chk_yx_position = yx_pos_r;
    assign bus.chk_enable      = chk_enable_r;
    assign bus.chk_event_kind  = chk_enable_r;
    assign bus.chk_mouse_xpos  = mouse_x_r;
    assign bus.chk_mouse_ypos  = mouse_y_r;
    assign busy                = busy_r;
    assign hit_valid           = hit_valid_r;
    assign hit_idx             = hit_idx_r;
    assign miss                = miss_r;

endmodule

// File: tb/tb_card_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_card_scan_controller
// Drives clicks into card_scan_controller with a behavioural register file and
// hit checker attached. A scan-level model expands each accepted click into the
// per-cycle expectations (which card is read, when the checker is loaded and
// enabled, the final hit/miss) and a compare process checks every cycle.
// Directed scans pin the model with hand-computed latencies and indices.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_card_scan_controller;
    localparam int N   = 16;
    localparam int IW  = 4;
    localparam int TMO = 15;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          click      = 1'b0;
    logic [11:0]   mouse_xpos = 12'd0;
    logic [11:0]   mouse_ypos = 12'd0;
    logic [N-1:0]  card_mask  = '0;
    logic          busy, hit_valid, miss, sync_err;
    logic [IW-1:0] hit_idx;

    card_scan_if #(.IDX_W(IW)) bus ();

    card_scan_controller #(.N_CARDS(N), .IDX_W(IW), .SYNC_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .click      (click),
        .mouse_xpos (mouse_xpos),
        .mouse_ypos (mouse_ypos),
        .card_mask  (card_mask),
        .bus        (bus),
        .busy       (busy),
        .hit_valid  (hit_valid),
        .hit_idx    (hit_idx),
        .miss       (miss),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- register file and checker ----------------
    logic [19:0]  mem [N];
    logic [N-1:0] hit_set    = '0;
    int           sync_delay [N];   // cycles until sync_done; 0 = never
    bit           noise_en   = 1'b0;
    logic [19:0]  loaded_pos = 20'd0;
    int           sd_cnt     = 0;

    assign bus.rf_data = bus.rf_rd_en ? mem[bus.rf_addr] : 20'h0;

    initial begin : checker_model
        int d;
        bus.chk_sync_done = 1'b0;
        bus.chk_event     = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                sd_cnt = 0;
                bus.chk_sync_done <= 1'b0;
                bus.chk_event     <= 1'b0;
            end else begin
                if (bus.chk_sync) begin
                    loaded_pos = bus.chk_yx_position;
                    d = sync_delay[loaded_pos[3:0]];
                    bus.chk_sync_done <= (d == 1);
                    sd_cnt = (d > 1) ? d - 1 : 0;
                end else if (sd_cnt > 0) begin
                    bus.chk_sync_done <= (sd_cnt == 1);
                    sd_cnt--;
                end else begin
                    bus.chk_sync_done <= 1'b0;
                end
                // Outside the cycle after an enable, optionally inject junk events.
                if (bus.chk_enable) bus.chk_event <= hit_set[loaded_pos[3:0]];
                else                bus.chk_event <= noise_en && ($urandom_range(0, 3) == 0);
            end
        end
    end

    // ---------------- scan-level reference model ----------------
    typedef struct packed {
        logic          busy, hv, ms, se, rd, sy, en;
        logic [IW-1:0] addr, hidx;
        logic [19:0]   pos;
    } exp_t;

    exp_t          q [$];
    exp_t          cur;
    logic [IW-1:0] m_hidx = '0;
    logic [11:0]   m_x = 12'd0, m_y = 12'd0;

    function automatic exp_t mk(input logic b, hv, ms, se, rd, sy, en,
                                input logic [IW-1:0] a, hi, input logic [19:0] p);
        exp_t r;
        r.busy = b; r.hv = hv; r.ms = ms; r.se = se; r.rd = rd; r.sy = sy; r.en = en;
        r.addr = a; r.hidx = hi; r.pos = p;
        return r;
    endfunction

    // Busy cycle with no strobes.
    task automatic push_busy(input int n);
        repeat (n) q.push_back(mk(1, 0, 0, 0, 0, 0, 0, '0, m_hidx, 20'd0));
    endtask

    // One scan: masked card = 1 cycle; unmasked card = select, read, load,
    // sync wait, check, evaluate. First hit ends it; otherwise a miss.
    task automatic build_scan(input logic [N-1:0] m);
        int hit = -1;
        for (int i = 0; i < N && hit < 0; i++) begin
            push_busy(1);
            if (m[i]) begin
                q.push_back(mk(1, 0, 0, 0, 1, 0, 0, IW'(i), m_hidx, 20'd0));
                q.push_back(mk(1, 0, 0, 0, 0, 1, 0, '0, m_hidx, mem[i]));
                if (sync_delay[i] == 0) begin
`ifdef CARD_SCAN_SYNC_TIMEOUT_EN
                    push_busy(TMO);
                    q.push_back(mk(0, 0, 0, 1, 0, 0, 0, '0, m_hidx, 20'd0));
`else
                    push_busy(200);
`endif
                    return;
                end
                push_busy(sync_delay[i]);
                q.push_back(mk(1, 0, 0, 0, 0, 0, 1, '0, m_hidx, 20'd0));
                push_busy(1);
                if (hit_set[i]) hit = i;
            end
        end
        if (hit >= 0) begin
            m_hidx = IW'(hit);
            q.push_back(mk(0, 1, 0, 0, 0, 0, 0, '0, m_hidx, 20'd0));
        end else begin
            q.push_back(mk(0, 0, 1, 0, 0, 0, 0, '0, m_hidx, 20'd0));
        end
    endtask

    initial begin : model
        cur = mk(0, 0, 0, 0, 0, 0, 0, '0, '0, 20'd0);
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                q.delete();
                m_hidx = '0; m_x = 12'd0; m_y = 12'd0;
                cur = mk(0, 0, 0, 0, 0, 0, 0, '0, '0, 20'd0);
            end else begin
                if (click && !cur.busy) begin
                    m_x = mouse_xpos;
                    m_y = mouse_ypos;
                    build_scan(card_mask);
                end
                if (q.size() > 0) cur = q.pop_front();
                else              cur = mk(0, 0, 0, 0, 0, 0, 0, '0, m_hidx, 20'd0);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_on) begin
                check("busy",       busy,               cur.busy);
                check("hit_valid",  hit_valid,          cur.hv);
                check("miss",       miss,               cur.ms);
                check("sync_err",   sync_err,           cur.se);
                check("hit_idx",    hit_idx,            cur.hidx);
                check("rf_rd_en",   bus.rf_rd_en,       cur.rd);
                check("chk_sync",   bus.chk_sync,       cur.sy);
                check("chk_enable", bus.chk_enable,     cur.en);
                check("event_kind", bus.chk_event_kind, cur.en);
                check("mouse_x",    bus.chk_mouse_xpos, m_x);
                check("mouse_y",    bus.chk_mouse_ypos, m_y);
                if (cur.rd) check("rf_addr",  bus.rf_addr,         cur.addr);
                if (cur.sy) check("position", bus.chk_yx_position, cur.pos);
            end
        end
    end

    // ---------------- directed helpers ----------------
    // Click, then watch until hit/miss/sync_err. cyc = edges after the click
    // edge; result = hit index, 100 = miss, 200 = sync_err, -1 = no end.
    task automatic run_scan(input logic [N-1:0] m, input logic [11:0] x, y, input bit extra,
                            output int cyc, output int reads, output int result,
                            output int first_addr);
        card_mask = m;
        @(posedge clk); #2;
        click = 1'b1; mouse_xpos = x; mouse_ypos = y;
        @(posedge clk); #2;
        click = 1'b0; mouse_xpos = 12'($urandom); mouse_ypos = 12'($urandom);
        cyc = 0; reads = 0; result = -1; first_addr = -1;
        while (cyc < 400 && result < 0) begin
            @(negedge clk);
            if (extra && cyc == 3) click = 1'b1;
            if (extra && cyc == 4) click = 1'b0;
            if (bus.rf_rd_en) begin
                if (reads == 0) first_addr = int'(bus.rf_addr);
                reads++;
            end
            if (hit_valid)     result = int'(hit_idx);
            else if (miss)     result = 100;
            else if (sync_err) result = 200;
            else               cyc++;
        end
        if (result < 0) check("scan_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    busy,                0);
        check({tag, "_hv"},      hit_valid,           0);
        check({tag, "_miss"},    miss,                0);
        check({tag, "_serr"},    sync_err,            0);
        check({tag, "_hidx"},    hit_idx,             0);
        check({tag, "_rd"},      bus.rf_rd_en,        0);
        check({tag, "_addr"},    bus.rf_addr,         0);
        check({tag, "_sync"},    bus.chk_sync,        0);
        check({tag, "_pos"},     bus.chk_yx_position, 0);
        check({tag, "_en"},      bus.chk_enable,      0);
        check({tag, "_kind"},    bus.chk_event_kind,  0);
        check({tag, "_mx"},      bus.chk_mouse_xpos,  0);
        check({tag, "_my"},      bus.chk_mouse_ypos,  0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #3 rst = 1'b0;
        #1 check_all_zero("rst");
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : stim
        int cyc, reads, res, fa, exp_res, quiet;
        for (int i = 0; i < N; i++) begin
            mem[i]        = {10'($urandom), 6'($urandom), 4'(i)};
            sync_delay[i] = 1;
        end
        #3 rst = 1'b0;
        #1 check_all_zero("por");
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        chk_on = 1'b1;

        // Only card 5 hits: six 6-cycle cards before the hit pulse.
        hit_set = 16'h0020;
        run_scan(16'hFFFF, 12'd100, 12'd200, 1'b0, cyc, reads, res, fa);
        check("t1_idx", res, 5);
        check("t1_cyc", cyc, 36);
        check("t1_reads", reads, 6);
        check("t1_mx", bus.chk_mouse_xpos, 100);
        check("t1_my", bus.chk_mouse_ypos, 200);

        // No hits anywhere: 16 full cards then a miss.
        hit_set = 16'h0000;
        run_scan(16'hFFFF, 12'd7, 12'd9, 1'b0, cyc, reads, res, fa);
        check("t2_res", res, 100);
        check("t2_cyc", cyc, 96);
        check("t2_reads", reads, 16);
        check("t2_busy", busy, 0);

        // Everything masked: one cycle per card, nothing read.
        run_scan(16'h0000, 12'd1, 12'd2, 1'b0, cyc, reads, res, fa);
        check("t3_res", res, 100);
        check("t3_cyc", cyc, 16);
        check("t3_reads", reads, 0);

        // Lowest-index hit wins; card 8 found after 8 skipped cards.
        hit_set = 16'h0101;
        run_scan(16'h0101, 12'd3, 12'd4, 1'b0, cyc, reads, res, fa);
        check("t4_idx", res, 0);
        check("t4_cyc", cyc, 6);
        check("t4_reads", reads, 1);
        run_scan(16'h0100, 12'd5, 12'd6, 1'b0, cyc, reads, res, fa);
        check("t5_idx", res, 8);
        check("t5_cyc", cyc, 14);
        check("t5_addr", fa, 8);

        // Random masks, hits, sync latencies, junk events and ignored clicks.
        noise_en = 1'b1;
        for (int t = 0; t < 12; t++) begin
            card_mask = N'($urandom);
            hit_set   = N'($urandom) & N'($urandom);
            for (int i = 0; i < N; i++) sync_delay[i] = $urandom_range(1, 3);
            exp_res = 100;
            for (int i = N - 1; i >= 0; i--) if (card_mask[i] && hit_set[i]) exp_res = i;
            run_scan(card_mask, 12'($urandom), 12'($urandom), 1'b1, cyc, reads, res, fa);
            check("rand_res", res, exp_res);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        noise_en = 1'b0;
        for (int i = 0; i < N; i++) sync_delay[i] = 1;

        // Card 0 never acknowledges: second click ignored, reset mid-wait.
        hit_set = 16'h0000;
        sync_delay[0] = 0;
        card_mask = 16'hFFFF;
        @(posedge clk); #2 click = 1'b1; mouse_xpos = 12'd11; mouse_ypos = 12'd22;
        @(posedge clk); #2 click = 1'b0;
        repeat (2) @(negedge clk);
        click = 1'b1;
        @(negedge clk);
        click = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", busy, 1);
        pulse_reset();
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (hit_valid || miss || busy) quiet++;
        end
        check("post_rst_quiet", quiet, 0);
        sync_delay[0] = 1;
        hit_set = 16'h0008;
        run_scan(16'hFFFF, 12'd33, 12'd44, 1'b0, cyc, reads, res, fa);
        check("restart_addr", fa, 0);
        check("restart_idx", res, 3);
        check("restart_cyc", cyc, 24);

        // Checker never acknowledges card 0.
        hit_set = 16'h0000;
        sync_delay[0] = 0;
`ifdef CARD_SCAN_SYNC_TIMEOUT_EN
        run_scan(16'hFFFF, 12'd55, 12'd66, 1'b0, cyc, reads, res, fa);
        check("tmo_res", res, 200);
        check("tmo_cyc", cyc, 18);
        check("tmo_reads", reads, 1);
        check("tmo_busy", busy, 0);
`else
        card_mask = 16'hFFFF;
        @(posedge clk); #2 click = 1'b1; mouse_xpos = 12'd55; mouse_ypos = 12'd66;
        @(posedge clk); #2 click = 1'b0;
        repeat (60) @(negedge clk);
        check("hang_busy", busy, 1);
        check("hang_serr", sync_err, 0);
        pulse_reset();
`endif
        sync_delay[0] = 1;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
